// File: rtl/mem_arbiter.sv
// mem_arbiter: gives one of NUM_CH requesters exclusive ownership of the
// single RAM port. Arbitration is fixed-priority or round-robin. A grant is
// held until the RAM signals mem_last, or until the burst watchdog fires.
//
// Handshake contract: a channel requests by holding ch_enable. It owns the
// port while its ch_grant bit is high. Ownership is released only by
// mem_last, by a watchdog abort (ch_timeout pulse) or by reset, so dropping
// ch_enable mid-burst has no effect. At least one IDLE cycle separates two
// grants.
module mem_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 0,
    parameter int TIMEOUT    = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         force_disable,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            ch_rw,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_write,
    input  logic [NUM_CH-1:0]            ch_op_size,
    input  logic [NUM_CH-1:0]            ch_finishes_op,
    output logic [NUM_CH-1:0]            ch_grant,
    output logic [DATA_WIDTH-1:0]        ch_read,
    output logic [NUM_CH-1:0]            ch_read_valid,
    output logic [NUM_CH-1:0]            ch_req_data,
    output logic [NUM_CH-1:0]            ch_last,
    output logic [NUM_CH-1:0]            ch_timeout,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_enable,
    output logic                         mem_rw,
    output logic [DATA_WIDTH-1:0]        mem_write,
    output logic                         mem_op_size,
    output logic                         mem_finishes_op,
    input  logic                         mem_write_req_input,
    input  logic [DATA_WIDTH-1:0]        mem_read,
    input  logic                         mem_read_valid,
    input  logic                         mem_last,
    output logic [0:0]                   o_dbg_state
);

    localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    logic [0:0]            r_state;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_last_owner;
    logic [CW-1:0]         r_wd_cnt;
    logic [NUM_CH-1:0]     r_grant;
    logic [NUM_CH-1:0]     r_timeout;

    logic [NUM_CH-1:0]     w_eligible;
    logic                  w_found;
    logic [OW-1:0]         w_winner;
    logic [NUM_CH-1:0]     w_win_1h;
    logic [NUM_CH-1:0]     w_own_1h;
    logic [ADDR_WIDTH-1:0] w_own_addr;
    logic [DATA_WIDTH-1:0] w_own_write;
    logic                  w_own_rw;
    logic                  w_own_op_size;
    logic                  w_own_finishes;
    logic                  w_busy;
    logic                  w_wd_expire;

    assign w_busy = (r_state == ST_BUSY);

    // A channel may compete unless it wants to write while writes are gated.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_eligible[i] = ch_enable[i] & ~(force_disable & (ch_rw[i] == MEM_WRITE));
        end
    end

    // Pick the winner: lowest index in fixed mode, or the first eligible
    // channel after the previous owner (wrapping) in round-robin mode.
    always_comb begin
        int v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                v_idx = (int'(r_last_owner) + 1 + k) % NUM_CH;
            end else begin
                v_idx = k;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_found && (i == v_idx) && w_eligible[i]) begin
                    w_found  = 1'b1;
                    w_winner = OW'(i);
                end
            end
        end
    end

    // Decode winner and current owner into one-hot vectors.
    always_comb begin
        w_win_1h = '0;
        w_own_1h = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_win_1h[i] = (w_winner == OW'(i));
            w_own_1h[i] = (r_owner == OW'(i));
        end
    end

    // Select the owner's request slice.
    always_comb begin
        w_own_addr     = '0;
        w_own_write    = '0;
        w_own_rw       = MEM_READ;
        w_own_op_size  = 1'b0;
        w_own_finishes = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_owner == OW'(i)) begin
                w_own_addr     = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_own_write    = ch_write[i*DATA_WIDTH +: DATA_WIDTH];
                w_own_rw       = ch_rw[i];
                w_own_op_size  = ch_op_size[i];
                w_own_finishes = ch_finishes_op[i];
            end
        end
    end

    // The watchdog fires on the TIMEOUT-th owned cycle; TIMEOUT=0 disables it.
    generate
        if (TIMEOUT > 0) begin : g_wd
            assign w_wd_expire = (r_wd_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign w_wd_expire = 1'b0;
        end
    endgenerate

    // Ownership FSM: grant from IDLE, release on mem_last or watchdog abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_CH - 1);
            r_wd_cnt     <= '0;
            r_grant      <= '0;
            r_timeout    <= '0;
        end else begin
            r_timeout <= '0;
            if (r_state == ST_IDLE) begin
                if (w_found) begin
                    r_state      <= ST_BUSY;
                    r_owner      <= w_winner;
                    r_last_owner <= w_winner;
                    r_grant      <= w_win_1h;
                    r_wd_cnt     <= '0;
                end
            end else begin
                if (mem_last) begin
                    // mem_last wins over a simultaneous watchdog expiry.
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end else if (w_wd_expire) begin
                    r_state   <= ST_IDLE;
                    r_grant   <= '0;
                    r_timeout <= w_own_1h;
                end else begin
                    r_wd_cnt <= r_wd_cnt + CW'(1);
                end
            end
        end
    end

    // Route the RAM port to and from the owner while BUSY; quiet when IDLE.
    always_comb begin
        mem_enable      = w_busy;
        mem_addr        = w_busy ? w_own_addr : '0;
        mem_rw          = w_busy ? w_own_rw : MEM_READ;
        mem_write       = w_busy ? w_own_write : '0;
        mem_op_size     = w_busy & w_own_op_size;
        mem_finishes_op = w_busy & w_own_finishes;
        ch_read_valid   = (w_busy && mem_read_valid) ? w_own_1h : '0;
        ch_req_data     = (w_busy && mem_write_req_input) ? w_own_1h : '0;
        ch_last         = (w_busy && mem_last) ? w_own_1h : '0;
    end

    assign ch_read     = mem_read;
    assign ch_grant    = r_grant;
    assign ch_timeout  = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that gives one requester at a time exclusive access to the single RAM port.
- Requesters include the inst cache, data cache, flash/UART loaders and future DMA.
- Generalises the fixed three-client controller:
  - configurable channel count and widths;
  - selectable fixed-priority or round-robin arbitration;
  - per-channel write blocking under force_disable;
  - a burst watchdog that aborts a transaction when mem_last never arrives.
- Sits between the cache/external clients and the RAM controller.

Parameters:
- NUM_CH, 3, number of requesting channels (2..8); channel 0 has highest fixed priority.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 256, maximum owned cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- force_disable  in  1  when high, write requests are not granted
- ch_enable  in  NUM_CH  per-channel request
- ch_rw  in  NUM_CH  per-channel direction (MEM_READ/MEM_WRITE)
- ch_addr  in  NUM_CH*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_write  in  NUM_CH*DATA_WIDTH  packed write data
- ch_op_size  in  NUM_CH  per-channel op size
- ch_finishes_op  in  NUM_CH  per-channel finish flag
- ch_grant  out  NUM_CH  one-hot owner indication, registered
- ch_read  out  DATA_WIDTH  mem_read broadcast to all channels
- ch_read_valid  out  NUM_CH  mem_read_valid routed to owner
- ch_req_data  out  NUM_CH  mem_write_req_input routed to owner
- ch_last  out  NUM_CH  mem_last routed to owner
- ch_timeout  out  NUM_CH  one-cycle abort pulse to the aborted owner
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_enable  out  1  RAM request
- mem_rw  out  1  RAM direction
- mem_write  out  DATA_WIDTH  RAM write data
- mem_op_size  out  1  forwarded op size
- mem_finishes_op  out  1  forwarded finish flag
- mem_write_req_input  in  1  RAM requests next write word
- mem_read  in  DATA_WIDTH  RAM read data
- mem_read_valid  in  1  RAM read data valid
- mem_last  in  1  final beat of the current transaction

Behaviour:
- Reset is asynchronous on rst_n low:
  - state IDLE, owner 0;
  - RR pointer set so channel 0 is checked first;
  - watchdog count 0, ch_grant 0, ch_timeout 0.
- Eligibility: eligible[i] = ch_enable[i] & !(force_disable & ch_rw[i]==MEM_WRITE).
- Winner selection:
  - Fixed mode: the lowest eligible index wins.
  - RR mode: search starts at (last_owner+1) mod NUM_CH and wraps; last_owner updates on every grant.
- States are IDLE and BUSY.
- IDLE:
  - All mem_* outputs are 0 (mem_rw = MEM_READ); all ch_* handshakes are 0.
  - If any channel is eligible at a posedge, the next state is BUSY, owner = winner, and ch_grant = onehot(owner).
  - Grant latency is 1 cycle from request.
- BUSY, combinational routing from the owner:
  - mem_enable = 1.
  - mem_addr, mem_rw, mem_write, mem_op_size and mem_finishes_op come from the owner's slice.
  - ch_read_valid, ch_req_data and ch_last are asserted only on the owner's bit.
  - ch_read = mem_read always.
- BUSY exit on mem_last:
  - At a posedge with mem_last high, the next state is IDLE and ch_grant clears.
  - There is at least one IDLE cycle between consecutive grants.
  - The owner's ch_enable dropping mid-transaction is ignored; only mem_last or timeout ends ownership.
- Watchdog, when TIMEOUT>0:
  - The counter clears on grant and increments each BUSY cycle.
  - If the counter equals TIMEOUT-1 and mem_last is low, the next state is IDLE and ch_timeout[owner] pulses for exactly one cycle, in that IDLE cycle.
  - If mem_last and the timeout condition occur in the same cycle, mem_last wins: normal completion, no pulse.
- force_disable rising while a write is already granted does not abort it; it only gates new grants.
- Reset mid-BUSY immediately drops mem_enable and ch_grant; no ch_last or ch_timeout is generated.

Test Plan:
- Fixed, NUM_CH=3: channels 0, 1 and 2 request together, each transaction ending with mem_last after 4 beats. Required: grant order 0,1,2, each grant 1 cycle after the prior IDLE cycle, and mem_addr following the owner's slice.
- RR_MODE=1: all three channels hold ch_enable continuously. Required: grant order 0,1,2,0,1,2; no channel is granted twice in a row while others wait.
- force_disable=1: ch0 requests a write and ch1 requests a read. Required: ch1 is granted and ch0 never is. Deasserting force_disable then yields a ch0 grant after ch1's mem_last.
- Routing: ch1 owns a read burst with mem_read=0xDEADBEEF and mem_read_valid=1. Required: ch_read_valid=3'b010, ch_read=0xDEADBEEF; the ch_last bit is set only on ch1 when mem_last=1.
- TIMEOUT=8: ch2 is granted and mem_last is never asserted. Required: mem_enable drops after 8 BUSY cycles and ch_timeout=3'b100 for one cycle. A variant with mem_last on the 8th cycle produces no pulse.
- Assert rst_n low during a ch0 BUSY burst. Required: mem_enable=0 and ch_grant=0 immediately; after release, ch0 (still requesting) is re-granted 1 cycle later.
